// File: rtl/ln_pkg.sv
// Shared types and helpers for the layernorm result streamer.
package ln_pkg;
  localparam int LN_DW        = 16;
  localparam int LN_FRAC_BITS = 8;

  typedef logic signed [LN_DW-1:0] ln_data_t;
  typedef enum logic {IDLE, STREAM} ln_state_e;

  // Clamp a wide signed value into the signed range of a dw-bit word.
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int unsigned dw);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi)      sat = hi;
    else if (v < lo) sat = lo;
    else             sat = v;
  endfunction
endpackage

// File: rtl/ln_norm_mac.sv
// Single-element normalize datapath: y = sat(((x - mean) * scale) >>> FB + beta).
// Define LN_ROUND_EN to add half an LSB before the shift (round-half-up).
module ln_norm_mac
  import ln_pkg::*;
#(
  parameter int DW = LN_DW,
  parameter int FB = LN_FRAC_BITS
) (
  input  logic [DW-1:0] x,
  input  logic [DW-1:0] mean,
  input  logic [DW-1:0] scale,
  input  logic [DW-1:0] beta,
  output logic [DW-1:0] y
);
  localparam int PW = 2*DW + 1;
`ifdef LN_ROUND_EN
  localparam logic [PW:0] HALF = {{PW{1'b0}}, 1'b1} << (FB - 1);
`endif

  logic signed [DW:0]   diff;
  logic signed [PW-1:0] prod;
  logic signed [PW:0]   rnd;
  logic signed [PW:0]   scaled;
  logic signed [PW:0]   sum;

  always_comb begin
    diff   = $signed({x[DW-1], x}) - $signed({mean[DW-1], mean});
    prod   = PW'(diff) * PW'($signed(scale));
`ifdef LN_ROUND_EN
    rnd    = (PW+1)'(prod) + $signed(HALF);
`else
    rnd    = (PW+1)'(prod);
`endif
    scaled = rnd >>> FB;
    sum    = scaled + (PW+1)'($signed(beta));
    y      = DW'(sat(64'(sum), DW));
  end
endmodule

// File: rtl/ln_norm_stream.sv
// Captures one layernorm row plus statistics and streams normalized elements
// out serially (index 0 first) over valid/ready; overruns set a sticky error.
module ln_norm_stream
  import ln_pkg::*;
#(
  parameter int DIM_SIZE   = 128,
  parameter int DATA_WIDTH = LN_DW,
  parameter int FRAC_BITS  = LN_FRAC_BITS,
  localparam int CW        = $clog2(DIM_SIZE)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [DIM_SIZE-1:0][DATA_WIDTH-1:0] array,
  input  logic [DATA_WIDTH-1:0]                equation,
  input  logic [DATA_WIDTH-1:0]                vari_remul,
  input  logic [DATA_WIDTH-1:0]                beta,
  input  logic                                 ln_valid,
  output logic                                 in_ready,
  output logic [DATA_WIDTH-1:0]                out_data,
  output logic [CW-1:0]                        out_idx,
  output logic                                 out_last,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 ovr_err
);
  ln_state_e                            state_q, state_d;
  logic                                 rdy_q, rdy_d;
  logic [DIM_SIZE-1:0][DATA_WIDTH-1:0]  arr_q, arr_d;
  logic [DATA_WIDTH-1:0]                mean_q, mean_d, scale_q, scale_d, beta_q, beta_d;
  logic [CW-1:0]                        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]                data_q, data_d;
  logic [CW-1:0]                        idx_q, idx_d;
  logic                                 last_q, last_d, vld_q, vld_d, ovr_q, ovr_d;
  logic [DATA_WIDTH-1:0]                y;

  ln_norm_mac #(.DW(DATA_WIDTH), .FB(FRAC_BITS)) u_mac (
    .x(arr_q[cnt_q]), .mean(mean_q), .scale(scale_q), .beta(beta_q), .y(y)
  );

  always_comb begin
    state_d = state_q;
    arr_d   = arr_q;
    mean_d  = mean_q;
    scale_d = scale_q;
    beta_d  = beta_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    idx_d   = idx_q;
    last_d  = last_q;
    vld_d   = vld_q;
    ovr_d   = ovr_q | (ln_valid & ~rdy_q);
    case (state_q)
      IDLE: begin
        if (ln_valid && rdy_q) begin
          arr_d   = array;
          mean_d  = equation;
          scale_d = vari_remul;
          beta_d  = beta;
          cnt_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        // The last element is never followed by a reload; its handshake ends the row.
        if (vld_q && last_q) begin
          if (out_ready) begin
            vld_d   = 1'b0;
            last_d  = 1'b0;
            state_d = IDLE;
          end
        end else if (!vld_q || out_ready) begin
          data_d = y;
          idx_d  = cnt_q;
          last_d = (cnt_q == CW'(DIM_SIZE - 1));
          vld_d  = 1'b1;
          cnt_d  = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      arr_q   <= '0;
      mean_q  <= '0;
      scale_q <= '0;
      beta_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      arr_q   <= arr_d;
      mean_q  <= mean_d;
      scale_q <= scale_d;
      beta_q  <= beta_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_data  = data_q;
  assign out_idx   = idx_q;
  assign out_last  = last_q;
  assign out_valid = vld_q;
  assign ovr_err   = ovr_q;
endmodule

// File: tb/tb_ln_norm_stream.sv
// Directed bench for ln_norm_stream with a 4-element row and hand-computed results.
module tb_ln_norm_stream;
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [3:0][15:0]  arr = '0;
  logic [15:0]       mean = '0, scale = '0, beta = '0;
  logic              ln_valid = 1'b0;
  logic              in_ready;
  logic [15:0]       out_data;
  logic [1:0]        out_idx;
  logic              out_last, out_valid, ovr_err;
  logic              out_ready = 1'b1;
  int                n_chk = 0, n_pass = 0;

  ln_norm_stream #(.DIM_SIZE(4), .DATA_WIDTH(16), .FRAC_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .array(arr), .equation(mean), .vari_remul(scale),
    .beta(beta), .ln_valid(ln_valid), .in_ready(in_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .ovr_err(ovr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, act, exp);
  endtask

  task automatic send_row(input logic [15:0] x0, x1, x2, x3, m, s, b);
    int w = 0;
    while (!in_ready && w < 40) begin @(negedge clk); w++; end
    chk("in_ready_before_send", in_ready, 1);
    arr[0] = x0; arr[1] = x1; arr[2] = x2; arr[3] = x3;
    mean = m; scale = s; beta = b;
    ln_valid = 1'b1;
    @(negedge clk);
    ln_valid = 1'b0;
    chk("lat_e0_valid", out_valid, 0);
  endtask

  task automatic expect_row(input logic [15:0] e0, e1, e2, e3,
                            input int stall_at, input int stall_n, input bit ovr);
    logic [15:0] e [4];
    int  k = 0, cyc = 0, stalled = 0;
    bit  seen = 0, pulsed = 0;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    while (k < 4 && cyc < 60) begin
      @(negedge clk); cyc++;
      ln_valid = 1'b0;
      if (ovr && k == 1 && !pulsed) begin
        arr[0] = 16'h7000; arr[1] = 16'h7000; arr[2] = 16'h7000; arr[3] = 16'h7000;
        mean = 16'h1234; ln_valid = 1'b1; pulsed = 1;
      end
      if (out_valid) begin
        if (!seen) begin chk("lat_first_data", cyc, 1); seen = 1; end
        chk($sformatf("data%0d", k), out_data, e[k]);
        chk($sformatf("idx%0d", k), out_idx, k);
        chk("in_ready_busy", in_ready, 0);
        if (k == stall_at && stalled < stall_n) begin
          out_ready = 1'b0; stalled++;
        end else begin
          out_ready = 1'b1;
          chk($sformatf("last%0d", k), out_last, (k == 3));
          k++;
        end
      end
    end
    if (k < 4) chk("row_timeout", k, 4);
    @(negedge clk);
    ln_valid = 1'b0;
    out_ready = 1'b1;
    chk("post_row_valid", out_valid, 0);
    chk("post_row_in_ready", in_ready, 1);
  endtask

  initial begin
    int w;
    int extra;
    // reset state
    @(negedge clk); @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ovr", ovr_err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", in_ready, 1);

    // basic row
    send_row(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0280, 16'h0100, 16'h0000);
    expect_row(16'hFE80, 16'hFF80, 16'h0080, 16'h0180, -1, 0, 0);

    // backpressure: idx 1 held for 3 cycles
    send_row(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0280, 16'h0100, 16'h0000);
    expect_row(16'hFE80, 16'hFF80, 16'h0080, 16'h0180, 1, 3, 0);

    // saturation high, plus neighbours of the positive limit
    send_row(16'h7FFF, 16'h8000, 16'hBFFF, 16'hC000, 16'h8000, 16'h0200, 16'h0000);
    expect_row(16'h7FFF, 16'h0000, 16'h7FFE, 16'h7FFF, -1, 0, 0);

    // saturation low, plus exact negative limit
    send_row(16'h8000, 16'h7FFF, 16'h3FFF, 16'h4000, 16'h7FFF, 16'h0200, 16'h0000);
    expect_row(16'h8000, 16'h0000, 16'h8000, 16'h8002, -1, 0, 0);

    // fractional scale with beta offset
    send_row(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0280, 16'h0180, 16'h0100);
    expect_row(16'hFEC0, 16'h0040, 16'h01C0, 16'h0340, -1, 0, 0);

    // overrun during stream
    chk("ovr_before", ovr_err, 0);
    send_row(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0280, 16'h0100, 16'h0000);
    expect_row(16'hFE80, 16'hFF80, 16'h0080, 16'h0180, -1, 0, 1);
    chk("ovr_set", ovr_err, 1);
    extra = 0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); if (out_valid) extra++; end
    chk("ovr_no_second_row", extra, 0);

    // rounding
    send_row(16'h0001, 16'hFFFF, 16'h0000, 16'h0002, 16'h0000, 16'h0080, 16'h0000);
`ifdef LN_ROUND_EN
    expect_row(16'h0001, 16'h0000, 16'h0000, 16'h0001, -1, 0, 0);
`else
    expect_row(16'h0000, 16'hFFFF, 16'h0000, 16'h0001, -1, 0, 0);
`endif
    chk("ovr_sticky", ovr_err, 1);

    // reset mid-stream after idx 1
    send_row(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0280, 16'h0100, 16'h0000);
    w = 0;
    while (!(out_valid && out_idx == 2'd1) && w < 20) begin @(negedge clk); w++; end
    chk("mid_idx1_seen", out_idx, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_idx", out_idx, 0);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_ovr", ovr_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rel_in_ready", in_ready, 1);
    chk("mid_rel_valid", out_valid, 0);
    send_row(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0280, 16'h0100, 16'h0000);
    expect_row(16'hFE80, 16'hFF80, 16'h0080, 16'h0180, -1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
